// File: rtl/traffic_light_nway_if.sv
// traffic_light_nway_if
//   Bundles the request inputs and lamp/status outputs of traffic_light_nway.
//   master : request source (drives ped_req, emg_req, emg_dir[, flash_req]),
//            observes lights, ped_walk, phase_idx and emg_active.
//   slave  : the controller itself.
//   Optional: TLC_FLASH_EN adds flash_req.
interface traffic_light_nway_if #(
  parameter int NUM_APPROACH = 4
);
  localparam int IW = $clog2(NUM_APPROACH);

`ifdef TLC_FLASH_EN
  logic                      flash_req;
`endif
  logic                      ped_req;
  logic                      emg_req;
  logic [IW-1:0]             emg_dir;
  logic [3*NUM_APPROACH-1:0] lights;
  logic                      ped_walk;
  logic [IW-1:0]             phase_idx;
  logic                      emg_active;

  modport master (
`ifdef TLC_FLASH_EN
    output flash_req,
`endif
    output ped_req, emg_req, emg_dir,
    input  lights, ped_walk, phase_idx, emg_active
  );

  modport slave (
`ifdef TLC_FLASH_EN
    input  flash_req,
`endif
    input  ped_req, emg_req, emg_dir,
    output lights, ped_walk, phase_idx, emg_active
  );
endinterface

// File: rtl/traffic_light_nway.sv
// traffic_light_nway
//   Round-robin N-approach signal controller with pedestrian scramble and
//   directed emergency preemption. Durations are in ticks of an internal
//   prescaler (TICK_DIV clk cycles per tick). All outputs are registered and
//   follow the state register by one cycle.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - traffic_light_nway_if.slave: ped_req, emg_req, emg_dir in;
//            lights ({R,Y,G} per approach), ped_walk, phase_idx, emg_active out
//   Optional: define TLC_FLASH_EN for the flashing-red mode (bus.flash_req).
module traffic_light_nway #(
  parameter int NUM_APPROACH = 4,
  parameter int TICK_DIV     = 50_000_000,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int PED_TICKS    = 10,
  parameter int TW           = 8
) (
  input logic                 clk,
  input logic                 rst,
  traffic_light_nway_if.slave bus
);
  localparam int IW = $clog2(NUM_APPROACH);
  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = 3 * NUM_APPROACH;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] G_END   = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] Y_END   = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] AR_END  = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] P_END   = TW'(PED_TICKS - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_APPROACH - 1);

  localparam logic [2:0]    RED     = 3'b100;
  localparam logic [2:0]    YELLOW  = 3'b010;
  localparam logic [2:0]    GREEN   = 3'b001;
  localparam logic [LW-1:0] ALL_RED = {NUM_APPROACH{RED}};
  localparam logic [LW-1:0] RST_LIGHTS = {{(NUM_APPROACH-1){RED}}, GREEN};

  typedef enum logic [2:0] {
    S_GREEN, S_YELLOW, S_ALLRED, S_PED, S_EMG_HOLD
`ifdef TLC_FLASH_EN
    , S_FLASH
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            ped_q, ped_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   edir_q, edir_d;
  logic            emg_prev_q;
  logic [LW-1:0]   lights_q, lights_d;
  logic            walk_q, walk_d;
  logic [IW-1:0]   pidx_q;
  logic            emga_q, emga_d;
`ifdef TLC_FLASH_EN
  logic            flash_ph_q, flash_ph_d;
`endif

  logic            tick;
  logic            emg_rise;
  logic            emg_now;
  logic [IW-1:0]   dir_in;
  logic [IW-1:0]   dir_now;

  assign tick     = (pre_q == PRE_MAX);
  assign pre_d    = tick ? '0 : pre_q + PW'(1);
  assign emg_rise = bus.emg_req & ~emg_prev_q;
  // Out-of-range directions fall back to approach 0.
  assign dir_in   = ({1'b0, bus.emg_dir} < (IW+1)'(NUM_APPROACH)) ? bus.emg_dir : '0;
  // A rise seen this cycle acts immediately; otherwise the latched request.
  assign emg_now  = pend_q | emg_rise;
  assign dir_now  = emg_rise ? dir_in : edir_q;
  assign edir_d   = emg_rise ? dir_in : edir_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_GREEN: begin
        if (emg_now) begin
          // Serving the preempted approach already: hold without a lamp change.
          state_d = (idx_q == dir_now) ? S_EMG_HOLD : S_YELLOW;
        end else if (tick && timer_q == G_END) begin
          state_d = S_YELLOW;
        end
      end
      // Yellow always clears through all-red before any other green.
      S_YELLOW: if (tick && timer_q == Y_END) state_d = S_ALLRED;
      S_ALLRED: begin
        if (tick && timer_q == AR_END) begin
          if (emg_now) begin
            state_d = S_EMG_HOLD;
            idx_d   = dir_now;
          end else if (idx_q == LAST) begin
            state_d = ped_q ? S_PED : S_GREEN;
            idx_d   = ped_q ? idx_q : '0;
          end else begin
            state_d = S_GREEN;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_PED: begin
        if (emg_now) begin
          state_d = S_ALLRED;
        end else if (tick && timer_q == P_END) begin
          state_d = S_GREEN;
          idx_d   = '0;
        end
      end
      S_EMG_HOLD: if (!bus.emg_req) state_d = S_YELLOW;
`ifdef TLC_FLASH_EN
      S_FLASH: begin
        if (!bus.flash_req || emg_now) begin
          state_d = S_ALLRED;
          idx_d   = LAST;
        end
      end
`endif
      default: begin
        state_d = S_GREEN;
        idx_d   = '0;
      end
    endcase
`ifdef TLC_FLASH_EN
    if (bus.flash_req && !emg_now && state_q != S_EMG_HOLD && state_q != S_FLASH) begin
      state_d = S_FLASH;
    end
`endif
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_q + TW'(1);
    end
`ifdef TLC_FLASH_EN
    if (state_q == S_FLASH && state_d == S_FLASH) timer_d = timer_q;
`endif

    pend_d = (state_d == S_EMG_HOLD) ? 1'b0 : (pend_q | emg_rise);
    ped_d  = (ped_q & ~(state_d == S_PED && state_q != S_PED)) | bus.ped_req;
`ifdef TLC_FLASH_EN
    if (state_q == S_FLASH) ped_d = ped_q;
`endif
  end

  // Registered outputs derived from the current state register.
  always_comb begin
    lights_d = ALL_RED;
    walk_d   = (state_q == S_PED);
    emga_d   = (state_q == S_EMG_HOLD);
    case (state_q)
      S_GREEN, S_EMG_HOLD: lights_d[3*int'(idx_q) +: 3] = GREEN;
      S_YELLOW:            lights_d[3*int'(idx_q) +: 3] = YELLOW;
`ifdef TLC_FLASH_EN
      S_FLASH:             lights_d = flash_ph_q ? '0 : ALL_RED;
`endif
      default:             lights_d = ALL_RED;
    endcase
`ifdef TLC_FLASH_EN
    flash_ph_d = (state_q == S_FLASH) ? (flash_ph_q ^ tick) : 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_GREEN;
      idx_q      <= '0;
      timer_q    <= '0;
      pre_q      <= '0;
      ped_q      <= 1'b0;
      pend_q     <= 1'b0;
      edir_q     <= '0;
      emg_prev_q <= 1'b0;
      lights_q   <= RST_LIGHTS;
      walk_q     <= 1'b0;
      pidx_q     <= '0;
      emga_q     <= 1'b0;
`ifdef TLC_FLASH_EN
      flash_ph_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      pre_q      <= pre_d;
      ped_q      <= ped_d;
      pend_q     <= pend_d;
      edir_q     <= edir_d;
      emg_prev_q <= bus.emg_req;
      lights_q   <= lights_d;
      walk_q     <= walk_d;
      pidx_q     <= idx_q;
      emga_q     <= emga_d;
`ifdef TLC_FLASH_EN
      flash_ph_q <= flash_ph_d;
`endif
    end
  end

  assign bus.lights     = lights_q;
  assign bus.ped_walk   = walk_q;
  assign bus.phase_idx  = pidx_q;
  assign bus.emg_active = emga_q;
endmodule

// File: tb/tb_traffic_light_nway.sv
// tb_traffic_light_nway
//   Scoreboard bench for traffic_light_nway (N=4, TICK_DIV=4, default
//   durations). Expected output segments (pattern + length in clk cycles) are
//   queued ahead of the stimulus; a monitor pops one per observed change.
module tb_traffic_light_nway;
  localparam int N = 4;
  localparam int TD = 4;

  typedef struct packed {
    logic [11:0] lights;
    logic        ped;
    logic        emg;
    logic [1:0]  idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  obs_t exp_pat[$];
  int   exp_len[$];

  traffic_light_nway_if #(.NUM_APPROACH(N)) tif ();

  traffic_light_nway #(
    .NUM_APPROACH(N),
    .TICK_DIV(TD),
    .GREEN_TICKS(10),
    .YELLOW_TICKS(3),
    .ALLRED_TICKS(1),
    .PED_TICKS(10),
    .TW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(tif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // kind: 0 = approach a green, 1 = approach a yellow, 2 = all red
  function automatic logic [11:0] lamp(input int a, input int kind);
    logic [11:0] v;
    v = {4{3'b100}};
    if (kind == 0) v[3*a +: 3] = 3'b001;
    else if (kind == 1) v[3*a +: 3] = 3'b010;
    return v;
  endfunction

  task automatic push(input int kind, input int a, input bit ped, input bit emg, input int len);
    obs_t e;
    e.lights = lamp(a, kind);
    e.ped    = ped;
    e.emg    = emg;
    e.idx    = 2'(a);
    exp_pat.push_back(e);
    exp_len.push_back(len);
  endtask

  task automatic push_g(input int a, input int len);    push(0, a, 1'b0, 1'b0, len); endtask
  task automatic push_hold(input int a, input int len); push(0, a, 1'b0, 1'b1, len); endtask
  task automatic push_ar(input int a, input int len);   push(2, a, 1'b0, 1'b0, len); endtask
  task automatic push_ped(input int len);               push(2, N-1, 1'b1, 1'b0, len); endtask
  task automatic push_ya(input int a, input int ylen);
    push(1, a, 1'b0, 1'b0, ylen);
    push_ar(a, 4);
  endtask
  task automatic push_round(input int from);
    for (int a = from; a < N; a++) begin
      push_g(a, 40);
      push_ya(a, 12);
    end
  endtask

  // Returns at the first negedge showing the requested pattern.
  task automatic wait_seg(input int kind, input int a, input bit ped, input bit emg);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (tif.lights == lamp(a, kind) && tif.ped_walk == ped &&
          tif.emg_active == emg && tif.phase_idx == 2'(a)) return;
      n++;
      if (n > 600) begin
        check("wait_timeout", 32'(n), 32'd0);
        return;
      end
    end
  endtask

  // Monitor: every output change closes a segment and opens the next.
  initial begin : monitor
    obs_t cur, prev, e;
    bit   have;
    int   cnt, cur_len;
    have = 1'b0;
    cnt = 0;
    cur_len = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {tif.lights, tif.ped_walk, tif.emg_active, tif.phase_idx};
        if (!have || cur != prev) begin
          if (have && cur_len != 0) check("seg_len", 32'(cnt), 32'(cur_len));
          if (exp_pat.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            cur_len = 0;
          end else begin
            e = exp_pat.pop_front();
            cur_len = exp_len.pop_front();
            check("lights", 32'(cur.lights), 32'(e.lights));
            check("ped_walk", 32'(cur.ped), 32'(e.ped));
            check("emg_active", 32'(cur.emg), 32'(e.emg));
            check("phase_idx", 32'(cur.idx), 32'(e.idx));
          end
          prev = cur;
          have = 1'b1;
          cnt = 1;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tif.ped_req = 1'b0;
    tif.emg_req = 1'b0;
    tif.emg_dir = '0;
`ifdef TLC_FLASH_EN
    tif.flash_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_lights", 32'(tif.lights), 32'(lamp(0, 0)));
    check("rst_ped_walk", 32'(tif.ped_walk), 32'd0);
    check("rst_emg_active", 32'(tif.emg_active), 32'd0);
    check("rst_phase_idx", 32'(tif.phase_idx), 32'd0);

    // Normal rotation, ped pulse in G1, second pulse during the scramble.
    push_g(0, 0); push_ya(0, 12); push_round(1);
    push_ped(40);
    push_round(0);
    push_ped(40);
    // Emergency to 2 from G0, then resume at 3.
    push_g(0, 22); push_ya(0, 10); push_hold(2, 32); push_ya(2, 12);
    push_round(3);
    // Emergency to the approach already green.
    push_g(0, 40); push_ya(0, 12);
    push_g(1, 7); push_hold(1, 12); push_ya(1, 9);
    push_round(2);
    // Emergency during the scramble, ped request retained.
    push_ped(10); push_ar(N-1, 2); push_hold(0, 12); push_ya(0, 12);
    push_round(1);
    push_ped(40);
    // Reset during hold with emg_req still high.
    push_g(0, 7); push_ya(0, 9); push_hold(3, 11);
    push_g(0, 2); push_ya(0, 11); push_hold(3, 8); push_ya(3, 12);
    push_g(0, 0);

    rst = 1'b0;
    mon_en = 1'b1;

    wait_seg(0, 1, 0, 0);
    tif.ped_req = 1'b1; @(negedge clk); tif.ped_req = 1'b0;
    wait_seg(2, N-1, 1, 0);
    repeat (5) @(negedge clk);
    tif.ped_req = 1'b1; @(negedge clk); tif.ped_req = 1'b0;
    wait_seg(0, 0, 0, 0);
    wait_seg(2, N-1, 1, 0);
    wait_seg(0, 0, 0, 0);

    repeat (20) @(negedge clk);
    tif.emg_dir = 2'd2; tif.emg_req = 1'b1;
    wait_seg(0, 2, 0, 1);
    repeat (30) @(negedge clk);
    tif.emg_req = 1'b0;

    wait_seg(0, 1, 0, 0);
    repeat (5) @(negedge clk);
    tif.emg_dir = 2'd1; tif.emg_req = 1'b1;
    wait_seg(0, 1, 0, 1);
    repeat (10) @(negedge clk);
    tif.emg_req = 1'b0;

    wait_seg(0, 2, 0, 0);
    tif.ped_req = 1'b1; @(negedge clk); tif.ped_req = 1'b0;
    wait_seg(2, N-1, 1, 0);
    repeat (8) @(negedge clk);
    tif.emg_dir = 2'd0; tif.emg_req = 1'b1; tif.ped_req = 1'b1;
    @(negedge clk); tif.ped_req = 1'b0;
    wait_seg(0, 0, 0, 1);
    repeat (10) @(negedge clk);
    tif.emg_req = 1'b0;

    wait_seg(2, N-1, 1, 0);
    wait_seg(0, 0, 0, 0);
    repeat (5) @(negedge clk);
    tif.emg_dir = 2'd3; tif.emg_req = 1'b1;
    wait_seg(0, 3, 0, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_emg_active", 32'(tif.emg_active), 32'd0);
    check("midrst_lights", 32'(tif.lights), 32'(lamp(0, 0)));
    rst = 1'b0;
    wait_seg(0, 3, 0, 1);
    repeat (6) @(negedge clk);
    tif.emg_req = 1'b0;

    wait_seg(0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("sb_left", 32'(exp_pat.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
